type_rule_lookup_pipe: RTL and testbench

Second-generation type-field rule lookup for the parser pipeline. It matches TYPE_NUM masked type fields against a RULE_NUM-entry rule table. A generic lowest-index-wins priority encoder resolves multiple hits. The winning rule's opaque result (type offsets, key offsets, head/meta shifts packed by the caller) is returned through a 2-stage valid/ready pipeline. Added over the previous generation: backpressure, hit/miss reporting, per-rule saturating hit counters, and a config readback port.

---
 rtl/type_rule_lookup_pipe_pkg.sv | 23 ++
 rtl/type_rule_lookup_pipe_if.sv | 59 +++++
 rtl/type_rule_lookup_pipe_prio_enc.sv | 28 ++
 rtl/type_rule_lookup_pipe.sv | 155 +++++++++++++++
 tb/tb_type_rule_lookup_pipe.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/type_rule_lookup_pipe_pkg.sv
// Shared constants and helpers for the type-field rule lookup.
// - Default field, result and counter widths.
// - idx_w: rule index width for a given table depth (at least one bit).
// - pack_result: builds the opaque result payload from its four 16-bit
//   fields: typeOffset, keyOffset, headShift, metaShift (MSB to LSB).
package type_rule_lookup_pipe_pkg;

  localparam int TYPE_WIDTH_DEF   = 16;
  localparam int RESULT_WIDTH_DEF = 64;
  localparam int CNT_WIDTH_DEF    = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] pack_result(input logic [15:0] type_off,
                                              input logic [15:0] key_off,
                                              input logic [15:0] head_shift,
                                              input logic [15:0] meta_shift);
    return {type_off, key_off, head_shift, meta_shift};
  endfunction

endpackage

// File: rtl/type_rule_lookup_pipe_if.sv
// Bus bundle for type_rule_lookup_pipe: lookup request/response handshake,
// rule table config write/read port, and counter controls.
// Handshake: a request transfers on a clock edge where i_valid & o_ready;
// a result transfers where o_valid & i_ready. i_valid must not depend on
// o_ready, and an unaccepted result holds o_valid and all o_* stable.
// Modports: master = requester/config agent, slave = lookup block.
interface type_rule_lookup_pipe_if
  import type_rule_lookup_pipe_pkg::*;
#(
  parameter int RULE_NUM     = 16,
  parameter int TYPE_NUM     = 2,
  parameter int TYPE_WIDTH   = TYPE_WIDTH_DEF,
  parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
);
  localparam int IDX_W = idx_w(RULE_NUM);
  localparam int TW    = TYPE_NUM * TYPE_WIDTH;

  logic                    i_valid;
  logic                    o_ready;
  logic [TW-1:0]           i_type;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_hit;
  logic [IDX_W-1:0]        o_hit_idx;
  logic [RESULT_WIDTH-1:0] o_result;
  logic                    i_cfg_wr;
  logic                    i_cfg_rd;
  logic [7:0]              i_cfg_idx;
  logic                    i_cfg_valid;
  logic [TW-1:0]           i_cfg_data;
  logic [TW-1:0]           i_cfg_mask;
  logic [RESULT_WIDTH-1:0] i_cfg_result;
  logic                    o_cfg_rvalid;
  logic                    o_cfg_rvalid_bit;
  logic [TW-1:0]           o_cfg_rdata;
  logic [TW-1:0]           o_cfg_rmask;
  logic [RESULT_WIDTH-1:0] o_cfg_rresult;
  logic [CNT_WIDTH-1:0]    o_cfg_rcnt;
  logic                    i_cnt_clr;
  logic [CNT_WIDTH-1:0]    o_miss_cnt;

  modport master (
    output i_valid, i_type, i_ready, i_cfg_wr, i_cfg_rd, i_cfg_idx,
           i_cfg_valid, i_cfg_data, i_cfg_mask, i_cfg_result, i_cnt_clr,
    input  o_ready, o_valid, o_hit, o_hit_idx, o_result, o_cfg_rvalid,
           o_cfg_rvalid_bit, o_cfg_rdata, o_cfg_rmask, o_cfg_rresult,
           o_cfg_rcnt, o_miss_cnt
  );

  modport slave (
    input  i_valid, i_type, i_ready, i_cfg_wr, i_cfg_rd, i_cfg_idx,
           i_cfg_valid, i_cfg_data, i_cfg_mask, i_cfg_result, i_cnt_clr,
    output o_ready, o_valid, o_hit, o_hit_idx, o_result, o_cfg_rvalid,
           o_cfg_rvalid_bit, o_cfg_rdata, o_cfg_rmask, o_cfg_rresult,
           o_cfg_rcnt, o_miss_cnt
  );

endinterface

// File: rtl/type_rule_lookup_pipe_prio_enc.sv
// prio_enc_onehot: generic lowest-index-wins priority encoder.
// Ports: req (request vector), grant (one-hot of lowest set req bit),
// idx (binary index of that bit, 0 when none), any (some req bit set).
module prio_enc_onehot #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last to overwrite.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/type_rule_lookup_pipe.sv
// type_rule_lookup_pipe: masked type-field lookup against a RULE_NUM-entry
// rule table, returning the winning rule's result through a 2-stage
// valid/ready pipeline, with per-rule/miss saturating counters and a
// config write/readback port.
// Ports: i_clk, i_rst (async, active high), bus (slave modport of
// type_rule_lookup_pipe_if carrying lookup, config and counter signals).
module type_rule_lookup_pipe
  import type_rule_lookup_pipe_pkg::*;
#(
  parameter int RULE_NUM     = 16,
  parameter int TYPE_NUM     = 2,
  parameter int TYPE_WIDTH   = TYPE_WIDTH_DEF,
  parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int PRIORITY_EN  = 1
) (
  input logic                   i_clk,
  input logic                   i_rst,
  type_rule_lookup_pipe_if.slave bus
);
  localparam int IDX_W = idx_w(RULE_NUM);
  localparam int TW    = TYPE_NUM * TYPE_WIDTH;

  logic [RULE_NUM-1:0]     rule_valid;
  logic [TW-1:0]           rule_data   [RULE_NUM];
  logic [TW-1:0]           rule_mask   [RULE_NUM];
  logic [RESULT_WIDTH-1:0] rule_result [RULE_NUM];
  logic [CNT_WIDTH-1:0]    hit_cnt     [RULE_NUM];
  logic [CNT_WIDTH-1:0]    miss_cnt;

  logic [RULE_NUM-1:0]     hit_vec, grant, cfg_sel;
  logic [IDX_W-1:0]        hit_idx;
  logic                    any_hit;
  logic [RESULT_WIDTH-1:0] sel_result;

  logic                    s1_valid, s1_hit, s2_valid, s2_hit;
  logic [IDX_W-1:0]        s1_idx, s2_idx;
  logic [RESULT_WIDTH-1:0] s1_result, s2_result;
  logic                    s1_load, s2_load, accept;

  // Comparing whole concatenated vectors equals the per-field compare.
  // Data bits outside the mask can never match, so such rules stay dead.
  always_comb begin
    hit_vec = '0;
    cfg_sel = '0;
    for (int i = 0; i < RULE_NUM; i++) begin
      hit_vec[i] = rule_valid[i] && ((rule_mask[i] & bus.i_type) == rule_data[i]);
      cfg_sel[i] = (bus.i_cfg_idx == 8'(i));
    end
  end

  prio_enc_onehot #(.WIDTH(RULE_NUM), .IDX_W(IDX_W)) u_prio (
    .req   (hit_vec),
    .grant (grant),
    .idx   (hit_idx),
    .any   (any_hit)
  );

  // Priority mode ORs only the granted entry; legacy mode ORs every hit.
  always_comb begin
    sel_result = '0;
    for (int i = 0; i < RULE_NUM; i++) begin
      if ((PRIORITY_EN != 0) ? grant[i] : hit_vec[i]) sel_result = sel_result | rule_result[i];
    end
  end

  assign s2_load = !s2_valid || bus.i_ready;
  assign s1_load = !s1_valid || s2_load;
  assign accept  = bus.i_valid && s1_load;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_hit    <= 1'b0;
      s1_idx    <= '0;
      s1_result <= '0;
      s2_valid  <= 1'b0;
      s2_hit    <= 1'b0;
      s2_idx    <= '0;
      s2_result <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_hit    <= any_hit;
          s1_idx    <= hit_idx;
          s1_result <= sel_result;
        end
      end
      if (s2_load) begin
        s2_valid  <= s1_valid;
        s2_hit    <= s1_hit;
        s2_idx    <= s1_idx;
        s2_result <= s1_result;
      end
    end
  end

  // Table payload carries no reset; only the valid bits do.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < RULE_NUM; i++) begin
      if (bus.i_cfg_wr && cfg_sel[i]) begin
        rule_data[i]   <= bus.i_cfg_data;
        rule_mask[i]   <= bus.i_cfg_mask;
        rule_result[i] <= bus.i_cfg_result;
      end
    end
  end

  // Valid bits, counters and readback. Readback samples pre-edge state, so
  // a same-cycle write to the read index returns the old entry and count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rule_valid           <= '0;
      miss_cnt             <= '0;
      bus.o_cfg_rvalid     <= 1'b0;
      bus.o_cfg_rvalid_bit <= 1'b0;
      bus.o_cfg_rdata      <= '0;
      bus.o_cfg_rmask      <= '0;
      bus.o_cfg_rresult    <= '0;
      bus.o_cfg_rcnt       <= '0;
      for (int i = 0; i < RULE_NUM; i++) hit_cnt[i] <= '0;
    end else begin
      bus.o_cfg_rvalid     <= bus.i_cfg_rd;
      bus.o_cfg_rvalid_bit <= 1'b0;
      bus.o_cfg_rdata      <= '0;
      bus.o_cfg_rmask      <= '0;
      bus.o_cfg_rresult    <= '0;
      bus.o_cfg_rcnt       <= '0;
      for (int i = 0; i < RULE_NUM; i++) begin
        if (bus.i_cfg_rd && cfg_sel[i]) begin
          bus.o_cfg_rvalid_bit <= rule_valid[i];
          bus.o_cfg_rdata      <= rule_data[i];
          bus.o_cfg_rmask      <= rule_mask[i];
          bus.o_cfg_rresult    <= rule_result[i];
          bus.o_cfg_rcnt       <= hit_cnt[i];
        end
        if (bus.i_cfg_wr && cfg_sel[i]) rule_valid[i] <= bus.i_cfg_valid;
        // Clear beats rule write, which beats a same-cycle hit increment.
        if (bus.i_cnt_clr || (bus.i_cfg_wr && cfg_sel[i])) hit_cnt[i] <= '0;
        else if (accept && grant[i] && (hit_cnt[i] != '1)) hit_cnt[i] <= hit_cnt[i] + CNT_WIDTH'(1);
      end
      if (bus.i_cnt_clr) miss_cnt <= '0;
      else if (accept && !any_hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.o_ready    = s1_load;
  assign bus.o_valid    = s2_valid;
  assign bus.o_hit      = s2_hit;
  assign bus.o_hit_idx  = s2_idx;
  assign bus.o_result   = s2_result;
  assign bus.o_miss_cnt = miss_cnt;

endmodule

// File: tb/tb_type_rule_lookup_pipe.sv
module tb_type_rule_lookup_pipe;
  import type_rule_lookup_pipe_pkg::*;

  localparam int RN = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  type_rule_lookup_pipe_if #(.RULE_NUM(RN), .CNT_WIDTH(CW)) ifa ();
  type_rule_lookup_pipe_if #(.RULE_NUM(RN), .CNT_WIDTH(CW)) ifb ();

  type_rule_lookup_pipe #(.RULE_NUM(RN), .CNT_WIDTH(CW), .PRIORITY_EN(1)) dut_a (
    .i_clk (clk), .i_rst (rst), .bus (ifa));
  type_rule_lookup_pipe #(.RULE_NUM(RN), .CNT_WIDTH(CW), .PRIORITY_EN(0)) dut_b (
    .i_clk (clk), .i_rst (rst), .bus (ifb));

  // Legacy-mode instance follows the same stimulus.
  assign ifb.i_valid      = ifa.i_valid;
  assign ifb.i_type       = ifa.i_type;
  assign ifb.i_ready      = ifa.i_ready;
  assign ifb.i_cfg_wr     = ifa.i_cfg_wr;
  assign ifb.i_cfg_rd     = ifa.i_cfg_rd;
  assign ifb.i_cfg_idx    = ifa.i_cfg_idx;
  assign ifb.i_cfg_valid  = ifa.i_cfg_valid;
  assign ifb.i_cfg_data   = ifa.i_cfg_data;
  assign ifb.i_cfg_mask   = ifa.i_cfg_mask;
  assign ifb.i_cfg_result = ifa.i_cfg_result;
  assign ifb.i_cnt_clr    = ifa.i_cnt_clr;

  logic [67:0] exp_q[$];
  logic [31:0] types [4];
  logic [67:0] held_val;
  logic [67:0] exp_v;
  int sent, got;
  logic held, saw_stall;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] idx, input logic vld, input logic [31:0] data,
                           input logic [31:0] mask, input logic [63:0] res);
    ifa.i_cfg_wr     = 1'b1;
    ifa.i_cfg_idx    = idx;
    ifa.i_cfg_valid  = vld;
    ifa.i_cfg_data   = data;
    ifa.i_cfg_mask   = mask;
    ifa.i_cfg_result = res;
    tick();
    ifa.i_cfg_wr = 1'b0;
  endtask

  task automatic cfg_read(input logic [7:0] idx);
    ifa.i_cfg_rd  = 1'b1;
    ifa.i_cfg_idx = idx;
    tick();
    ifa.i_cfg_rd = 1'b0;
  endtask

  initial begin
    ifa.i_valid = 1'b0; ifa.i_type = '0; ifa.i_ready = 1'b1;
    ifa.i_cfg_wr = 1'b0; ifa.i_cfg_rd = 1'b0; ifa.i_cfg_idx = '0;
    ifa.i_cfg_valid = 1'b0; ifa.i_cfg_data = '0; ifa.i_cfg_mask = '0;
    ifa.i_cfg_result = '0; ifa.i_cnt_clr = 1'b0;
    types[0] = 32'h0800_0001; types[1] = 32'h1234_56AA;
    types[2] = 32'h0000_0000; types[3] = 32'h0800_FFFF;

    // clock/reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", 72'(ifa.o_valid), 72'(0));
    check("rst_o_hit", 72'(ifa.o_hit), 72'(0));
    check("rst_o_result", 72'(ifa.o_result), 72'(0));
    check("rst_o_hit_idx", 72'(ifa.o_hit_idx), 72'(0));
    check("rst_miss_cnt", 72'(ifa.o_miss_cnt), 72'(0));
    check("rst_cfg_rvalid", 72'(ifa.o_cfg_rvalid), 72'(0));
    check("rst_legacy_valid", 72'(ifb.o_valid), 72'(0));
    rst = 1'b0;
    tick();
    check("ready_after_rst", 72'(ifa.o_ready), 72'(1));

    // table setup
    cfg_write(8'd3, 1'b1, 32'h0800_0000, 32'hFFFF_0000, pack_result(16'h1, 16'h2, 16'h3, 16'h4));
    cfg_write(8'd2, 1'b1, 32'h0000_00AA, 32'h0000_00FF, 64'h0000_0000_0000_00F0);
    cfg_write(8'd5, 1'b1, 32'h0000_000A, 32'h0000_000F, 64'h0F00_0000_0000_0000);
    cfg_write(8'd6, 1'b1, 32'h0000_0100, 32'h0000_0000, 64'h5555);
    cfg_write(8'd1, 1'b1, 32'h0000_0066, 32'h0000_00FF, 64'h2222);

    // single hit on rule 3, latency 2
    ifa.i_valid = 1'b1; ifa.i_type = 32'h0800_1234;
    tick();
    ifa.i_valid = 1'b0;
    check("lat1_not_valid", 72'(ifa.o_valid), 72'(0));
    tick();
    check("r3_valid", 72'(ifa.o_valid), 72'(1));
    check("r3_hit", 72'(ifa.o_hit), 72'(1));
    check("r3_idx", 72'(ifa.o_hit_idx), 72'(3));
    check("r3_result", 72'(ifa.o_result), 72'(64'h0001_0002_0003_0004));
    tick();
    cfg_read(8'd3);
    check("r3_rvalid", 72'(ifa.o_cfg_rvalid), 72'(1));
    check("r3_rvalid_bit", 72'(ifa.o_cfg_rvalid_bit), 72'(1));
    check("r3_rdata", 72'(ifa.o_cfg_rdata), 72'(32'h0800_0000));
    check("r3_rmask", 72'(ifa.o_cfg_rmask), 72'(32'hFFFF_0000));
    check("r3_cnt", 72'(ifa.o_cfg_rcnt), 72'(1));
    tick();
    check("rvalid_one_cycle", 72'(ifa.o_cfg_rvalid), 72'(0));

    // rules 2 and 5 both hit
    ifa.i_valid = 1'b1; ifa.i_type = 32'h1234_56AA;
    tick();
    ifa.i_valid = 1'b0;
    tick();
    check("multi_idx", 72'(ifa.o_hit_idx), 72'(2));
    check("multi_result", 72'(ifa.o_result), 72'(64'h00F0));
    check("legacy_hit", 72'(ifb.o_hit), 72'(1));
    check("legacy_idx", 72'(ifb.o_hit_idx), 72'(2));
    check("legacy_result", 72'(ifb.o_result), 72'(64'h0F00_0000_0000_00F0));
    tick();
    cfg_read(8'd5);
    check("r5_cnt_not_winner", 72'(ifa.o_cfg_rcnt), 72'(0));
    check("r5_cnt_legacy", 72'(ifb.o_cfg_rcnt), 72'(0));

    // miss
    check("miss_before", 72'(ifa.o_miss_cnt), 72'(0));
    ifa.i_valid = 1'b1; ifa.i_type = 32'h0000_0000;
    tick();
    ifa.i_valid = 1'b0;
    tick();
    check("miss_valid", 72'(ifa.o_valid), 72'(1));
    check("miss_hit", 72'(ifa.o_hit), 72'(0));
    check("miss_idx", 72'(ifa.o_hit_idx), 72'(0));
    check("miss_result", 72'(ifa.o_result), 72'(0));
    check("miss_after", 72'(ifa.o_miss_cnt), 72'(1));
    tick();

    // streaming with backpressure; scoreboard in order
    exp_q.push_back({1'b1, 3'd3, 64'h0001_0002_0003_0004});
    exp_q.push_back({1'b1, 3'd2, 64'h0000_0000_0000_00F0});
    exp_q.push_back({1'b0, 3'd0, 64'h0});
    exp_q.push_back({1'b1, 3'd3, 64'h0001_0002_0003_0004});
    sent = 0; got = 0; held = 1'b0; saw_stall = 1'b0; held_val = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      ifa.i_ready = !(cyc >= 2 && cyc <= 4);
      ifa.i_valid = (sent < 4);
      ifa.i_type  = types[(sent < 4) ? sent : 0];
      #1;
      if (held)
        check("stream_hold", {3'b0, ifa.o_valid, ifa.o_hit, ifa.o_hit_idx, ifa.o_result},
              {3'b0, 1'b1, held_val});
      if (!ifa.o_ready) saw_stall = 1'b1;
      if (ifa.o_valid && ifa.i_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 68'hF_FFFF_FFFF_FFFF_FFFF;
        check("stream_data", 72'({ifa.o_hit, ifa.o_hit_idx, ifa.o_result}), 72'(exp_v));
        got++;
      end
      held     = ifa.o_valid && !ifa.i_ready;
      held_val = {ifa.o_hit, ifa.o_hit_idx, ifa.o_result};
      if (ifa.i_valid && ifa.o_ready) sent++;
      tick();
    end
    ifa.i_valid = 1'b0; ifa.i_ready = 1'b1;
    check("stream_count", 72'(got), 72'(4));
    check("stream_left", 72'(exp_q.size()), 72'(0));
    check("stream_stall_seen", 72'(saw_stall), 72'(1));
    tick();
    check("stream_no_dup", 72'(ifa.o_valid), 72'(0));
    cfg_read(8'd3);
    check("r3_cnt_stream", 72'(ifa.o_cfg_rcnt), 72'(3));
    check("miss_stream", 72'(ifa.o_miss_cnt), 72'(2));

    // write rule 1 with same-cycle lookup + read, next-cycle lookup
    ifa.i_cfg_rd = 1'b1; ifa.i_valid = 1'b1; ifa.i_type = 32'h0000_0055;
    cfg_write(8'd1, 1'b1, 32'h0000_0055, 32'h0000_00FF, 64'h1111);
    ifa.i_cfg_rd = 1'b0;
    check("wr_rd_old_bit", 72'(ifa.o_cfg_rvalid_bit), 72'(1));
    check("wr_rd_old_data", 72'(ifa.o_cfg_rdata), 72'(32'h66));
    check("wr_rd_old_result", 72'(ifa.o_cfg_rresult), 72'(64'h2222));
    tick();
    ifa.i_valid = 1'b0;
    check("wr_old_hit", 72'(ifa.o_hit), 72'(0));
    check("wr_old_result", 72'(ifa.o_result), 72'(0));
    tick();
    check("wr_new_hit", 72'(ifa.o_hit), 72'(1));
    check("wr_new_idx", 72'(ifa.o_hit_idx), 72'(1));
    check("wr_new_result", 72'(ifa.o_result), 72'(64'h1111));
    tick();
    cfg_write(8'd9, 1'b1, 32'h0000_0077, 32'h0000_00FF, 64'h9999);
    cfg_read(8'd1);
    check("r1_data_kept", 72'(ifa.o_cfg_rdata), 72'(32'h55));
    check("r1_cnt", 72'(ifa.o_cfg_rcnt), 72'(1));
    cfg_read(8'd9);
    check("oor_rvalid", 72'(ifa.o_cfg_rvalid), 72'(1));
    check("oor_bit", 72'(ifa.o_cfg_rvalid_bit), 72'(0));
    check("oor_data", 72'(ifa.o_cfg_rdata), 72'(0));
    check("oor_result", 72'(ifa.o_cfg_rresult), 72'(0));
    check("oor_cnt", 72'(ifa.o_cfg_rcnt), 72'(0));
    check("miss_three", 72'(ifa.o_miss_cnt), 72'(3));

    // saturation on rule 0 (matches everything)
    cfg_write(8'd0, 1'b1, 32'h0, 32'h0, 64'hABCD);
    ifa.i_valid = 1'b1; ifa.i_type = 32'hDEAD_BEEF;
    repeat (20) tick();
    ifa.i_valid = 1'b0;
    tick(); tick();
    cfg_read(8'd0);
    check("sat_cnt", 72'(ifa.o_cfg_rcnt), 72'(15));
    check("sat_cnt_legacy", 72'(ifb.o_cfg_rcnt), 72'(15));
    ifa.i_valid = 1'b1;
    cfg_write(8'd0, 1'b1, 32'h0, 32'h0, 64'hABCD);
    ifa.i_valid = 1'b0;
    tick(); tick();
    cfg_read(8'd0);
    check("wr_hit_same_cycle", 72'(ifa.o_cfg_rcnt), 72'(0));
    ifa.i_valid = 1'b1;
    tick();
    ifa.i_valid = 1'b0;
    tick(); tick();
    cfg_read(8'd0);
    check("cnt_one", 72'(ifa.o_cfg_rcnt), 72'(1));
    ifa.i_valid = 1'b1; ifa.i_cnt_clr = 1'b1;
    tick();
    ifa.i_valid = 1'b0; ifa.i_cnt_clr = 1'b0;
    tick(); tick();
    cfg_read(8'd0);
    check("clr_wins", 72'(ifa.o_cfg_rcnt), 72'(0));
    check("clr_miss", 72'(ifa.o_miss_cnt), 72'(0));

    // reset mid-stream
    ifa.i_valid = 1'b1;
    tick(); tick();
    check("pre_rst_valid", 72'(ifa.o_valid), 72'(1));
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 72'(ifa.o_valid), 72'(0));
    check("async_rst_hit", 72'(ifa.o_hit), 72'(0));
    check("async_rst_result", 72'(ifa.o_result), 72'(0));
    ifa.i_valid = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    cfg_read(8'd3);
    check("rst_r3_invalid", 72'(ifa.o_cfg_rvalid_bit), 72'(0));
    cfg_read(8'd0);
    check("rst_r0_invalid", 72'(ifa.o_cfg_rvalid_bit), 72'(0));
    check("rst_no_valid", 72'(ifa.o_valid), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
